// File: rtl/ram_loader_if.sv
// Byte-stream handshake and RAM strobe bus between ram_loader (master) and its environment.
interface ram_loader_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic [7:0] ram_a;
  logic       ram_sa;
  logic       ram_s;
  logic       ram_e;
  logic [7:0] ram_d_in;
  logic [7:0] ram_d_out;

  modport master (
    input  byte_in,
    input  byte_valid,
    input  ram_d_out,
    output byte_ready,
    output ram_a,
    output ram_sa,
    output ram_s,
    output ram_e,
    output ram_d_in
  );

  modport slave (
    output byte_in,
    output byte_valid,
    output ram_d_out,
    input  byte_ready,
    input  ram_a,
    input  ram_sa,
    input  ram_s,
    input  ram_e,
    input  ram_d_in
  );
endinterface

// File: rtl/ram_loader.sv
// ram_loader: writes a byte stream into consecutive RAM locations via address-set/data-set strobes.
// Optional readback check of every written byte is compiled in with `define LOADER_VERIFY_EN.
module ram_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [7:0]   base_addr,
  input  logic [8:0]   length,
  output logic         busy,
  output logic         cpu_hold,
  output logic         done,
  output logic         timeout,
  output logic         verify_err,
  output logic [8:0]   load_count,
  ram_loader_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitByte,
    StSetAddr,
    StWrite,
`ifdef LOADER_VERIFY_EN
    StVerify,
`endif
    StFinish
  } state_e;

  localparam bit          TimeoutEn   = (TIMEOUT_CYCLES != 0);
  localparam int unsigned WaitLastInt = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [9:0]  WaitLast    = WaitLastInt[9:0];

  state_e     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [8:0] len_q, len_d;
  logic [8:0] cnt_q, cnt_d;
  logic [7:0] hold_q, hold_d;
  logic [9:0] wait_q, wait_d;
  logic       timeout_q, timeout_d;
  logic       advance;
`ifdef LOADER_VERIFY_EN
  logic       verr_q, verr_d;
`else
  logic [7:0] unused_rd;
  assign unused_rd = bus.ram_d_out;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      hold_q    <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
`ifdef LOADER_VERIFY_EN
      verr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
`ifdef LOADER_VERIFY_EN
      verr_q    <= verr_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
`ifdef LOADER_VERIFY_EN
    verr_d    = verr_q;
`endif
    advance   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d    = base_addr;
          len_d     = length;
          cnt_d     = '0;
          wait_d    = '0;
          timeout_d = 1'b0;
`ifdef LOADER_VERIFY_EN
          verr_d    = 1'b0;
`endif
          state_d   = (length == 9'd0) ? StFinish : StWaitByte;
        end
      end
      StWaitByte: begin
        if (bus.byte_valid) begin
          hold_d  = bus.byte_in;
          state_d = StSetAddr;
        end else if (TimeoutEn && (wait_q == WaitLast)) begin
          timeout_d = 1'b1;
          state_d   = StFinish;
        end else begin
          wait_d = wait_q + 10'd1;
        end
      end
      StSetAddr: state_d = StWrite;
      StWrite: begin
`ifdef LOADER_VERIFY_EN
        state_d = StVerify;
`else
        advance = 1'b1;
`endif
      end
`ifdef LOADER_VERIFY_EN
      StVerify: begin
        // Mismatch is only flagged; the load carries on.
        if (bus.ram_d_out != hold_q) verr_d = 1'b1;
        advance = 1'b1;
      end
`endif
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    if (advance) begin
      cnt_d  = cnt_q + 9'd1;
      addr_d = addr_q + 8'd1;
      if ((cnt_q + 9'd1) == len_q) begin
        state_d = StFinish;
      end else begin
        state_d = StWaitByte;
        wait_d  = '0;
      end
    end
  end

  assign busy           = (state_q != StIdle);
  assign cpu_hold       = busy;
  assign done           = (state_q == StFinish);
  assign timeout        = timeout_q;
  assign load_count     = cnt_q;
  assign bus.byte_ready = (state_q == StWaitByte);
  assign bus.ram_a      = busy ? addr_q : 8'h00;
  assign bus.ram_sa     = (state_q == StSetAddr);
  assign bus.ram_s      = (state_q == StWrite);
  assign bus.ram_d_in   = (state_q == StWrite) ? hold_q : 8'h00;
`ifdef LOADER_VERIFY_EN
  assign bus.ram_e      = (state_q == StVerify);
  assign verify_err     = verr_q;
`else
  assign bus.ram_e      = 1'b0;
  assign verify_err     = 1'b0;
`endif

endmodule
